// File: rtl/mul8_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// default operand width and the controller state encodings.
package mul8_seq_pkg;

    localparam int MUL_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    // Counter width able to hold 0..width-1, never narrower than one bit.
    function automatic int cnt_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mul8_seq_addern.sv
// Structural ripple-carry adder: s/c = a + b + cin built from full-adder cells.
module addern #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c = carry[WIDTH];

endmodule

// File: rtl/mul8_seq.sv
// Sequential unsigned multiplier: one shift-and-add step per RUN cycle,
// WIDTH steps per product, result held in q until the next completion.
module mul8_seq
    import mul8_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] q
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mul_state_t state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] q_q, q_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum_s;
    logic               sum_c;
    logic [2*WIDTH:0]   step_full;
    logic [2*WIDTH-1:0] step_shifted;

    assign addend = mplier_q[0] ? mcand_q : '0;

    addern #(
        .WIDTH (WIDTH)
    ) u_addern (
        .a   (acc_q),
        .b   (addend),
        .cin (1'b0),
        .s   (sum_s),
        .c   (sum_c)
    );

    // The carry-out is kept as the top bit so the whole (WIDTH+1)-bit sum shifts in.
    assign step_full    = {sum_c, sum_s, mplier_q};
    assign step_shifted = step_full[2*WIDTH:1];

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        q_d      = q_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = a;
                    mplier_d = b;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d    = step_shifted[2*WIDTH-1:WIDTH];
                mplier_d = step_shifted[WIDTH-1:0];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    q_d     = step_shifted;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            q_q      <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign q    = q_q;

endmodule

// File: tb/tb_mul8_seq.sv
// Directed and random checks of mul8_seq against hand-computed and a*b products.
module tb_mul8_seq;

    localparam int W = 8;
    localparam int LATENCY = W + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   aIn = '0;
    logic [W-1:0]   bIn = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] q;

    int testsRun = 0;
    int testsFailed = 0;

    mul8_seq #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (aIn),
        .b     (bIn),
        .busy  (busy),
        .done  (done),
        .q     (q)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Pulses start for one cycle with the given operands; returns on the
    // negedge after the accepting edge (edge 1 of the operation).
    task automatic applyStimulus(input logic [W-1:0] aVal, input logic [W-1:0] bVal);
        @(negedge clk);
        start = 1'b1;
        aIn   = aVal;
        bIn   = bVal;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Walks forward until done, counting edges since acceptance (inclusive).
    task automatic waitForDone(input string tag, input int startEdge,
                               output int edges, output int busyCycles);
        edges = startEdge;
        busyCycles = 0;
        while (!done && edges < 40) begin
            if (busy) busyCycles++;
            @(negedge clk);
            edges++;
        end
        checkOutput({tag, "_doneSeen"}, 32'(done), 32'd1);
        checkOutput({tag, "_exclusive"}, 32'(busy & done), 32'd0);
    endtask

    task automatic runOp(input logic [W-1:0] aVal, input logic [W-1:0] bVal,
                         input logic [31:0] expected, input string tag);
        int edges;
        int busyCycles;
        applyStimulus(aVal, bVal);
        waitForDone(tag, 1, edges, busyCycles);
        checkOutput({tag, "_latency"}, 32'(edges), 32'(LATENCY));
        checkOutput({tag, "_busyCycles"}, 32'(busyCycles), 32'(W));
        checkOutput({tag, "_q"}, 32'(q), expected);
        @(negedge clk);
        checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_qHold"}, 32'(q), expected);
    endtask

    initial begin
        int edges;
        int busyCycles;
        int doneCount;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_q", 32'(q), 32'd0);

        runOp(8'd13, 8'd11, 32'd143, "mul_13x11");
        runOp(8'd255, 8'd255, 32'd65025, "mul_255x255");
        runOp(8'd0, 8'd200, 32'd0, "mul_0x200");
        runOp(8'd200, 8'd0, 32'd0, "mul_200x0");
        runOp(8'd1, 8'd1, 32'd1, "mul_1x1");
        runOp(8'd128, 8'd2, 32'd256, "mul_128x2");
        runOp(8'd170, 8'd85, 32'd14450, "mul_170x85");

        // start during RUN must neither restart nor resample operands
        applyStimulus(8'd3, 8'd5);
        repeat (3) @(negedge clk);
        start = 1'b1;
        aIn   = 8'd7;
        bIn   = 8'd7;
        @(negedge clk);
        start = 1'b0;
        waitForDone("ignore_start", 5, edges, busyCycles);
        checkOutput("ignore_start_latency", 32'(edges), 32'(LATENCY));
        checkOutput("ignore_start_q", 32'(q), 32'd15);
        @(negedge clk);
        checkOutput("ignore_start_single", 32'(done), 32'd0);
        checkOutput("ignore_start_idle", 32'(busy), 32'd0);

        // reset in the middle of a run aborts with no done pulse
        applyStimulus(8'd100, 8'd100);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_q", 32'(q), 32'd0);
        doneCount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("abort_noDone", 32'(doneCount), 32'd0);
        runOp(8'd2, 8'd3, 32'd6, "after_abort");

        // reset wins over start on the same edge
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        aIn   = 8'd9;
        bIn   = 8'd9;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst_over_start_busy", 32'(busy), 32'd0);
        checkOutput("rst_over_start_q", 32'(q), 32'd0);

        // start held through DONE chains operations with no IDLE gap
        @(negedge clk);
        start = 1'b1;
        aIn   = 8'd6;
        bIn   = 8'd7;
        @(negedge clk);
        aIn   = 8'd9;
        bIn   = 8'd9;
        waitForDone("b2b_first", 1, edges, busyCycles);
        checkOutput("b2b_first_latency", 32'(edges), 32'(LATENCY));
        checkOutput("b2b_first_q", 32'(q), 32'd42);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_noGap", 32'(busy), 32'd1);
        checkOutput("b2b_qHold", 32'(q), 32'd42);
        waitForDone("b2b_second", 1, edges, busyCycles);
        checkOutput("b2b_second_latency", 32'(edges), 32'(LATENCY));
        checkOutput("b2b_second_q", 32'(q), 32'd81);
        @(negedge clk);

        for (int i = 0; i < 220; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            runOp(ra, rb, 32'(int'(ra) * int'(rb)), "random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
